pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first:
  clk  in  1  system clock; all state updates on rising edge.
  rst  in  1  synchronous, active-high reset.
  stallreq_if  in  1  instruction-fetch (icache miss) stall request.
  stallreq_id  in  1  decode (load-use) stall request.
  stallreq_ex  in  1  execute (mul/div busy) stall request.
  stallreq_mem  in  1  memory (dcache miss) stall request.
  excepttype_i  in  32  exception code from MEM stage; 0 = none.
  cp0_epc_i  in  32  current CP0 EPC.
  stall  out  6  stall bus; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
  flush  out  1  pipeline-wide flush to all stage registers.
  new_pc  out  32  redirect PC, valid only while flush=1.
  stall_cycles  out  32  count of cycles with stall[0]=1.
  flush_count  out  16  count of flush pulses.
REQ-002 SHALL use these parameters: EXC_VECTOR, default 32'hBFC00380, general exception entry; ERET_CODE, default 32'h0000000E, excepttype value selecting EPC return.

Function
REQ-003 SHALL implement a 3-state FSM: IDLE, CAPTURE, FLUSH.
REQ-004 In IDLE with excepttype_i==0, stall SHALL be combinational from requests, priority mem > ex > id > if: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 6'b000000.
REQ-005 In IDLE with excepttype_i!=0 and stallreq_mem=1, FSM SHALL stay IDLE, stall per REQ-004 (6'b011111), no capture; exception is held by the stalled MEM stage.
REQ-006 In IDLE with excepttype_i!=0 and stallreq_mem=0, FSM SHALL move to CAPTURE next edge and register exc_code <= excepttype_i, epc <= cp0_epc_i.
REQ-007 In CAPTURE, stall SHALL be 6'b011111 regardless of requests, flush=0; next state FLUSH unconditionally.
REQ-008 In FLUSH, flush SHALL be 1, stall SHALL be 6'b000000, new_pc SHALL be epc if exc_code==ERET_CODE else EXC_VECTOR; next state IDLE.
REQ-009 Outside FLUSH, flush SHALL be 0 and new_pc SHALL be 32'h0.
REQ-010 excepttype_i and stall requests SHALL be ignored in CAPTURE and FLUSH (younger instructions are discarded by the flush).
REQ-011 Exception-to-flush latency SHALL be 2 cycles from the IDLE capture edge; flush pulse SHALL be exactly 1 cycle; back-to-back exceptions SHALL yield flush pulses at least 3 cycles apart.
REQ-012 stall_cycles SHALL increment by 1 on each edge where stall[0]==1, wrapping 32'hFFFFFFFF -> 0.
REQ-013 flush_count SHALL increment by 1 on each edge where flush==1, wrapping 16'hFFFF -> 0.
REQ-014 stall SHALL always be thermometer-coded: if bit k=1 then all bits below k are 1.

Reset
REQ-015 rst=1 at a rising edge SHALL force state IDLE, exc_code=0, epc=0, stall_cycles=0, flush_count=0, overriding all other inputs including mid-CAPTURE/FLUSH.
REQ-016 While in IDLE after reset with all inputs 0: stall=6'b000000, flush=0, new_pc=0.

Verification
REQ-017 Reset, all requests 0 -> stall=000000, flush=0, counters 0.
REQ-018 stallreq_id=1 and stallreq_ex=1 same cycle -> stall=6'b001111; held 5 cycles -> stall_cycles=5.
REQ-019 excepttype_i=32'h8 in IDLE, no mem stall -> next cycle stall=6'b011111, following cycle flush=1, new_pc=32'hBFC00380, then IDLE; flush_count=1.
REQ-020 excepttype_i=32'hE, cp0_epc_i=32'h80001234 -> flush cycle new_pc=32'h80001234.
REQ-021 excepttype_i=32'hC with stallreq_mem=1 for 3 cycles -> stall=6'b011111 for those 3 cycles, no capture; capture on the edge after stallreq_mem drops, flush 2 cycles later.
REQ-022 rst asserted during CAPTURE -> next cycle IDLE, flush never asserted, counters 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with exception redirect
//
// Purpose:
//   Merges per-stage stall requests into a thermometer-coded stall bus and
//   turns a MEM-stage exception into a one-cycle pipeline-wide flush with a
//   redirect PC. Also keeps free-running counters of stalled and flush cycles.
//
// Ports:
//   clk           in   1   system clock, rising edge
//   rst           in   1   synchronous, active-high reset
//   stallreq_if   in   1   fetch stall request (icache miss)
//   stallreq_id   in   1   decode stall request (load-use)
//   stallreq_ex   in   1   execute stall request (mul/div busy)
//   stallreq_mem  in   1   memory stall request (dcache miss)
//   excepttype_i  in  32   exception code from MEM, 0 = none
//   cp0_epc_i     in  32   current CP0 EPC
//   stall         out  6   bit0 PC .. bit5 WB, 1 = hold
//   flush         out  1   flush all stage registers
//   new_pc        out 32   redirect PC, meaningful only while flush = 1
//   stall_cycles  out 32   cycles with stall[0] = 1 (wraps)
//   flush_count   out 16   flush pulses issued (wraps)

module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
   parameter logic [31:0] ERET_CODE  = 32'h0000000E
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   // Stall patterns: a requesting stage holds itself and everything older.
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   state_t      state_q, state_d;
   logic [31:0] exc_code_q, exc_code_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q, flush_count_d;

   logic [5:0]  req_stall;
   logic        exc_pending;

   // Youngest-stage-wins priority: a MEM stall must also freeze EX/ID/IF.
   always_comb begin
      req_stall = STALL_NONE;
      if (stallreq_mem) begin
         req_stall = STALL_MEM;
      end else if (stallreq_ex) begin
         req_stall = STALL_EX;
      end else if (stallreq_id) begin
         req_stall = STALL_ID;
      end else if (stallreq_if) begin
         req_stall = STALL_IF;
      end
   end

   assign exc_pending = (excepttype_i != 32'd0);

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      stall      = STALL_NONE;
      flush      = 1'b0;
      new_pc     = 32'd0;

      case (state_q)
         IDLE: begin
            stall = req_stall;
            // While MEM is stalled the excepting instruction is still held
            // there, so the capture waits until the stall releases.
            if (exc_pending && !stallreq_mem) begin
               state_d    = CAPTURE;
               exc_code_d = excepttype_i;
               epc_d      = cp0_epc_i;
            end
         end
         CAPTURE: begin
            // Freeze everything up to MEM for one cycle so the redirect PC
            // is resolved from registered values before the flush.
            stall   = STALL_MEM;
            state_d = FLUSH;
         end
         FLUSH: begin
            flush   = 1'b1;
            new_pc  = (exc_code_q == ERET_CODE) ? epc_q : EXC_VECTOR;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Counters track the outputs actually presented this cycle.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (stall[0]) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (flush) begin
         flush_count_d = flush_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         exc_code_q     <= 32'd0;
         epc_q          <= 32'd0;
         stall_cycles_q <= 32'd0;
         flush_count_q  <= 16'd0;
      end else begin
         state_q        <= state_d;
         exc_code_q     <= exc_code_d;
         epc_q          <= epc_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;

endmodule
